// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch FSM encoding and the canonical NOP.
package rv32i_types;

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Holds a fetched instruction while IF/ID is stalled; resets and clears to NOP.
module fetch_hold_buf
    import rv32i_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load_i) begin
            buf_d = data_i;
        end else if (clear_i) begin
            buf_d = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= NOP_INST;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign data_o = buf_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch-stage PC generator and I-cache requester with stall hold and redirect squash.
module if_fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            true_branch,
    input  logic [XLEN-1:0] branch_pc,
    input  logic            inst_mem_resp,
    input  logic [XLEN-1:0] inst_mem_rdata,
    output logic            inst_mem_read,
    output logic [XLEN-1:0] inst_mem_address,
    output logic [XLEN-1:0] IF_inst,
    output logic [XLEN-1:0] IF_pc,
    output logic            IF_valid
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            active_q;
    logic            buf_load;
    logic            buf_clear;
    logic            valid_c;
    logic            read_c;
    logic [XLEN-1:0] buf_inst;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (inst_mem_rdata),
        .data_o  (buf_inst)
    );

    // Next-state and pass-through outputs; nothing issues until the cycle after reset release.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        valid_c   = 1'b0;
        read_c    = 1'b0;
        if (active_q) begin
            case (state_q)
                FETCH: begin
                    read_c = 1'b1;
                    if (inst_mem_resp) begin
                        if (true_branch) begin
                            pc_d = branch_pc;
                        end else begin
                            valid_c = 1'b1;
                            if (stall) begin
                                buf_load = 1'b1;
                                state_d  = HOLD;
                            end else begin
                                pc_d = pc_q + 32'd4;
                            end
                        end
                    end else if (true_branch) begin
                        pend_d  = branch_pc;
                        state_d = DISCARD;
                    end
                end
                HOLD: begin
                    valid_c = !true_branch;
                    if (true_branch) begin
                        pc_d      = branch_pc;
                        buf_clear = 1'b1;
                        state_d   = FETCH;
                    end else if (!stall) begin
                        pc_d      = pc_q + 32'd4;
                        buf_clear = 1'b1;
                        state_d   = FETCH;
                    end
                end
                DISCARD: begin
                    read_c = 1'b1;
                    if (true_branch) begin
                        pend_d = branch_pc;
                    end
                    // Stale read must complete before the address may move.
                    if (inst_mem_resp) begin
                        pc_d    = true_branch ? branch_pc : pend_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            active_q <= 1'b1;
        end
    end

    assign inst_mem_read    = read_c;
    assign inst_mem_address = {pc_q[XLEN-1:2], 2'b00};
    assign IF_valid         = valid_c;
    assign IF_pc            = pc_q;
    assign IF_inst          = !valid_c          ? NOP_INST :
                              (state_q == HOLD) ? buf_inst : inst_mem_rdata;

endmodule
